// File: rtl/audio_pkg.sv
// audio_pkg: shared types and default constants for the serial audio transmitter.
//   state_t      : link state (IDLE / RUN)
//   SAMPLE_W     : default sample width
//   SLOT_BITS    : default bclk periods per channel slot
//   BCLK_DIV     : default clk cycles per bclk half-period
//   FRAME_CYCLES : clk cycles per stereo frame at the defaults
//   ptr_width()  : counter width helper that never returns zero
package audio_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int SAMPLE_W       = 7;
    localparam int SLOT_BITS      = 16;
    localparam int BCLK_DIV       = 4;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int FRAME_CYCLES   = 4 * SLOT_BITS * BCLK_DIV;

    // Width of a counter that must hold 0..n-1; a 1-entry range still needs one bit.
    function automatic int ptr_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: synchronous sample FIFO between the tone generators and the serial link.
//   clk, reset_n : clock and synchronous active-low reset
//   push, pop    : write / read requests (ignored when full / empty respectively)
//   wr_data      : sample to store
//   rd_data      : current head of the FIFO (valid while empty is low)
//   level        : registered occupancy
//   full, empty  : registered occupancy flags
module audio_sample_fifo import audio_pkg::*; #(
    parameter int WIDTH      = SAMPLE_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              wr_data,
    output logic [WIDTH-1:0]              rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          full,
    output logic                          empty
);

    localparam int PTR_W = ptr_width(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_DEPTH = LVL_W'(FIFO_DEPTH);

    logic [WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             full_r;
    logic             empty_r;
    logic             do_push_s;
    logic             do_pop_s;
    logic [LVL_W-1:0] level_next_s;

    // Qualify requests against the registered flags and form the next occupancy.
    always_comb begin
        do_push_s    = push && !full_r;
        do_pop_s     = pop && !empty_r;
        level_next_s = level_r;
        if (do_push_s && !do_pop_s) begin
            level_next_s = level_r + LVL_ONE;
        end else if (!do_push_s && do_pop_s) begin
            level_next_s = level_r - LVL_ONE;
        end else begin
            level_next_s = level_r;
        end
    end

    // Sample storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy and flags; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r <= level_next_s;
            full_r  <= (level_next_s == LVL_DEPTH);
            empty_r <= (level_next_s == '0);
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign level   = level_r;
    assign full    = full_r;
    assign empty   = empty_r;

endmodule

// File: rtl/audio_serial_tx.sv
// audio_serial_tx: buffers mono samples and sends each one in both slots of a
// left-justified serial frame (bclk, lrclk, sdata, MSB first).
//   clk, reset_n : clock and synchronous active-low reset
//   en           : link enable; dropping it abandons the current frame
//   s_data       : signed sample from the generator
//   s_valid      : s_data valid
//   s_ready      : FIFO has room (registered, independent of en)
//   bclk         : bit clock, 2*BCLK_DIV clk cycles per period
//   lrclk        : 0 = left slot, 1 = right slot
//   sdata        : serial data, changes only as bclk falls or at a frame load
//   frame_start  : one-cycle pulse when a new frame word is loaded
//   underrun     : sticky, set whenever a frame is loaded from an empty FIFO
//   fifo_level   : FIFO occupancy
module audio_serial_tx #(
    parameter int WIDTH      = audio_pkg::SAMPLE_W,
    parameter int SLOT_BITS  = audio_pkg::SLOT_BITS,
    parameter int BCLK_DIV   = audio_pkg::BCLK_DIV,
    parameter int FIFO_DEPTH = audio_pkg::DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          en,
    input  logic [WIDTH-1:0]              s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          bclk,
    output logic                          lrclk,
    output logic                          sdata,
    output logic                          frame_start,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    import audio_pkg::*;

    localparam int DIV_W = ptr_width(BCLK_DIV);
    localparam int BIT_W = $clog2(2 * SLOT_BITS);
    localparam int PAD   = SLOT_BITS - WIDTH;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [BIT_W:0]   BIT_ONE   = (BIT_W + 1)'(1);
    localparam logic [BIT_W:0]   BIT_SLOT  = (BIT_W + 1)'(SLOT_BITS);
    localparam logic [BIT_W:0]   BIT_FRAME = (BIT_W + 1)'(2 * SLOT_BITS);

    state_t                state_r;
    logic [DIV_W-1:0]      div_cnt_r;
    logic                  bclk_r;
    logic [BIT_W-1:0]      bit_cnt_r;
    logic [SLOT_BITS-1:0]  word_r;
    logic                  sdata_r;
    logic                  lrclk_r;
    logic                  frame_start_r;
    logic                  underrun_r;

    logic                  tick_s;
    logic                  fall_s;
    logic [BIT_W:0]        bit_next_s;
    logic [BIT_W:0]        slot_pos_s;
    logic                  lr_next_s;
    logic [SLOT_BITS-1:0]  shifted_s;
    logic                  load_s;
    logic [SLOT_BITS-1:0]  load_word_s;
    logic                  push_s;
    logic                  pop_s;

    logic [WIDTH-1:0]      fifo_rd_data_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;

    audio_sample_fifo #(
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data (s_data),
        .rd_data (fifo_rd_data_s),
        .level   (fifo_level),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // Divider wrap, falling-edge detect, next bit position and the frame-load decision.
    always_comb begin
        tick_s     = (div_cnt_r == DIV_LAST);
        fall_s     = tick_s && bclk_r;
        bit_next_s = {1'b0, bit_cnt_r} + BIT_ONE;
        if (bit_next_s >= BIT_SLOT) begin
            slot_pos_s = bit_next_s - BIT_SLOT;
            lr_next_s  = 1'b1;
        end else begin
            slot_pos_s = bit_next_s;
            lr_next_s  = 1'b0;
        end
        // The bit to send is the slot position counted from the word MSB.
        shifted_s = word_r << slot_pos_s;
        load_s    = 1'b0;
        case (state_r)
            IDLE:    load_s = en;
            RUN:     load_s = en && fall_s && (bit_next_s == BIT_FRAME);
            default: load_s = 1'b0;
        endcase
        if (fifo_empty_s) begin
            load_word_s = '0;
        end else begin
            // Left-justify the sample in the slot; unsigned extension keeps the pad at zero.
            load_word_s = SLOT_BITS'(fifo_rd_data_s) << PAD;
        end
        push_s = s_valid && !fifo_full_s;
        pop_s  = load_s && !fifo_empty_s;
    end

    // Link state machine with divider, bit counter and registered serial outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            div_cnt_r     <= '0;
            bclk_r        <= 1'b0;
            bit_cnt_r     <= '0;
            word_r        <= '0;
            sdata_r       <= 1'b0;
            lrclk_r       <= 1'b0;
            frame_start_r <= 1'b0;
            underrun_r    <= 1'b0;
        end else if (load_s) begin
            state_r       <= RUN;
            div_cnt_r     <= '0;
            bclk_r        <= 1'b0;
            bit_cnt_r     <= '0;
            word_r        <= load_word_s;
            sdata_r       <= load_word_s[SLOT_BITS-1];
            lrclk_r       <= 1'b0;
            frame_start_r <= 1'b1;
            if (fifo_empty_s) begin
                underrun_r <= 1'b1;
            end
        end else begin
            frame_start_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    div_cnt_r <= '0;
                    bclk_r    <= 1'b0;
                    bit_cnt_r <= '0;
                    sdata_r   <= 1'b0;
                    lrclk_r   <= 1'b0;
                end
                RUN: begin
                    if (!en) begin
                        // Abandon the partial frame; queued samples stay in the FIFO.
                        state_r   <= IDLE;
                        div_cnt_r <= '0;
                        bclk_r    <= 1'b0;
                        bit_cnt_r <= '0;
                        word_r    <= '0;
                        sdata_r   <= 1'b0;
                        lrclk_r   <= 1'b0;
                    end else if (tick_s) begin
                        div_cnt_r <= '0;
                        bclk_r    <= ~bclk_r;
                        if (bclk_r) begin
                            // Falling bclk: advance to the next bit; rising edges leave data alone.
                            bit_cnt_r <= bit_next_s[BIT_W-1:0];
                            sdata_r   <= shifted_s[SLOT_BITS-1];
                            lrclk_r   <= lr_next_s;
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_ONE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    div_cnt_r <= '0;
                    bclk_r    <= 1'b0;
                    bit_cnt_r <= '0;
                    word_r    <= '0;
                    sdata_r   <= 1'b0;
                    lrclk_r   <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready     = ~fifo_full_s;
    assign bclk        = bclk_r;
    assign lrclk       = lrclk_r;
    assign sdata       = sdata_r;
    assign frame_start = frame_start_r;
    assign underrun    = underrun_r;

endmodule

// File: tb/tb_audio_serial_tx.sv
// Bench for audio_serial_tx: a frame-timing model (sample queue plus time since the
// last frame load) predicts every output on every cycle, and directed literal checks
// pin the model at hand-computed points.
module tb_audio_serial_tx;

    localparam int WIDTH = 7;
    localparam int SLOT  = 16;
    localparam int DIV   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 4 * SLOT * DIV;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk     = 1'b0;
    logic             reset_n = 1'b0;
    logic             en      = 1'b0;
    logic             s_valid = 1'b0;
    logic [WIDTH-1:0] s_data  = '0;
    logic             s_ready;
    logic             bclk;
    logic             lrclk;
    logic             sdata;
    logic             frame_start;
    logic             underrun;
    logic [LW-1:0]    fifo_level;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    audio_serial_tx #(
        .WIDTH      (WIDTH),
        .SLOT_BITS  (SLOT),
        .BCLK_DIV   (DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .bclk        (bclk),
        .lrclk       (lrclk),
        .sdata       (sdata),
        .frame_start (frame_start),
        .underrun    (underrun),
        .fifo_level  (fifo_level)
    );

    // ---------------- behavioural model ----------------
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_word = '0;
    bit               m_run  = 1'b0;
    bit               m_under = 1'b0;
    bit               m_live = 1'b0;
    bit               m_ld;
    int               m_t = 0;
    int               m_lvl;

    always @(posedge clk) begin
        if (!reset_n) begin
            q.delete();
            m_run   = 1'b0;
            m_t     = 0;
            m_under = 1'b0;
            m_word  = '0;
            m_live  = 1'b1;
        end else begin
            m_lvl = q.size();
            m_ld  = 1'b0;
            if (!m_run) begin
                m_ld = en;
            end else if (!en) begin
                m_run = 1'b0;
                m_t   = 0;
            end else begin
                m_t = m_t + 1;
                if (m_t == FRAME) m_ld = 1'b1;
            end
            if (m_ld) begin
                m_run = 1'b1;
                m_t   = 0;
                if (q.size() > 0) begin
                    m_word = q.pop_front();
                end else begin
                    m_word  = '0;
                    m_under = 1'b1;
                end
            end
            if (s_valid && (m_lvl < DEPTH)) q.push_back(s_data);
        end
    end

    // ---------------- per-cycle compare ----------------
    int               c_bit;
    int               c_pos;
    logic [WIDTH-1:0] c_tmp;
    logic             e_fs, e_bclk, e_lr, e_sd, e_rdy;
    logic [LW-1:0]    e_lvl;

    always @(posedge clk) begin
        #1;
        if (m_live) begin
            if (m_run) begin
                c_bit  = m_t / (2 * DIV);
                c_pos  = c_bit % SLOT;
                c_tmp  = m_word << c_pos;
                e_fs   = (m_t == 0);
                e_bclk = ((m_t / DIV) % 2) == 1;
                e_lr   = (c_bit >= SLOT);
                e_sd   = (c_pos < WIDTH) ? c_tmp[WIDTH-1] : 1'b0;
            end else begin
                e_fs   = 1'b0;
                e_bclk = 1'b0;
                e_lr   = 1'b0;
                e_sd   = 1'b0;
            end
            e_rdy = (q.size() < DEPTH);
            e_lvl = LW'(q.size());
            n_checks++;
            if ({frame_start, bclk, lrclk, sdata, underrun, s_ready, fifo_level} !==
                {e_fs, e_bclk, e_lr, e_sd, m_under, e_rdy, e_lvl}) begin
                n_fail++;
                $display("FAIL model t=%0d got fs=%b bclk=%b lr=%b sd=%b ur=%b rdy=%b lvl=%0d exp fs=%b bclk=%b lr=%b sd=%b ur=%b rdy=%b lvl=%0d",
                         m_t, frame_start, bclk, lrclk, sdata, underrun, s_ready, fifo_level,
                         e_fs, e_bclk, e_lr, e_sd, m_under, e_rdy, e_lvl);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        s_data  = d;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // Advance to the negedge where the model's frame time equals x (bounded).
    task automatic wait_t(input int x);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (m_t != x && guard < 3000);
        if (m_t != x) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_t timeout target=%0d", x);
        end
    endtask

    logic [WIDTH-1:0] vals [5];
    logic [WIDTH-1:0] late [3];

    initial begin
        vals[0] = 7'h51; vals[1] = 7'h22; vals[2] = 7'h63; vals[3] = 7'h14; vals[4] = 7'h35;
        late[0] = 7'h7F; late[1] = 7'h00; late[2] = 7'h40;

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset_outs", {31'd0, bclk | lrclk | sdata | frame_start | underrun}, 32'd0);
        chk("reset_level", 32'(fifo_level), 32'd0);
        chk("reset_ready", 32'(s_ready), 32'd1);

        // One sample 0x41, then enable.
        push(7'h41);
        chk("push1_level", 32'(fifo_level), 32'd1);
        en = 1'b1;
        @(negedge clk);                       // t=0
        chk("t0_fs", 32'(frame_start), 32'd1);
        chk("t0_sd", 32'(sdata), 32'd1);
        repeat (8) @(negedge clk);            // t=8, bit 1
        chk("t8_sd", 32'(sdata), 32'd0);
        chk("t8_bclk", 32'(bclk), 32'd0);
        repeat (4) @(negedge clk);            // t=12
        chk("t12_bclk", 32'(bclk), 32'd1);
        repeat (36) @(negedge clk);           // t=48, bit 6
        chk("t48_sd", 32'(sdata), 32'd1);
        chk("t48_lr", 32'(lrclk), 32'd0);
        repeat (8) @(negedge clk);            // t=56, bit 7 (pad)
        chk("t56_sd", 32'(sdata), 32'd0);
        repeat (120) @(negedge clk);          // t=176, right slot bit 6
        chk("t176_lr", 32'(lrclk), 32'd1);
        chk("t176_sd", 32'(sdata), 32'd1);
        repeat (80) @(negedge clk);           // t=256: next frame, FIFO empty
        chk("t256_fs", 32'(frame_start), 32'd1);
        chk("t256_ur", 32'(underrun), 32'd1);
        wait_t(100);
        push(7'h33);
        chk("ur_sticky", 32'(underrun), 32'd1);
        en = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("rst2_ur", 32'(underrun), 32'd0);

        // Fill with s_valid held: only four accepted.
        for (int i = 0; i < 5; i++) begin
            s_data  = vals[i];
            s_valid = 1'b1;
            @(negedge clk);
        end
        s_valid = 1'b0;
        chk("full_level", 32'(fifo_level), 32'd4);
        chk("full_ready", 32'(s_ready), 32'd0);
        en = 1'b1;
        @(negedge clk);
        chk("f0_sd", 32'(sdata), 32'd1);
        chk("f0_level", 32'(fifo_level), 32'd3);

        // Pushes coinciding with frame-load pops keep the level constant.
        for (int k = 0; k < 3; k++) begin
            wait_t(FRAME - 1);
            s_data  = late[k];
            s_valid = 1'b1;
            @(negedge clk);
            s_valid = 1'b0;
            chk("ovl_level", 32'(fifo_level), 32'd3);
            chk("ovl_fs", 32'(frame_start), 32'd1);
        end

        // Frame carrying 0x7F, dropped at bit 10, then resumed.
        wait_t(FRAME - 1);
        @(negedge clk);
        chk("x7f_sd", 32'(sdata), 32'd1);
        chk("x7f_level", 32'(fifo_level), 32'd2);
        wait_t(80);
        en = 1'b0;
        @(negedge clk);
        chk("drop_outs", {29'd0, bclk, lrclk, sdata}, 32'd0);
        chk("drop_level", 32'(fifo_level), 32'd2);
        repeat (3) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        chk("resume_fs", 32'(frame_start), 32'd1);
        chk("resume_sd", 32'(sdata), 32'd0);
        chk("resume_level", 32'(fifo_level), 32'd1);

        // Drain to an underrun, queue three, then reset mid-frame.
        wait_t(FRAME - 1);
        wait_t(FRAME - 1);
        @(negedge clk);
        chk("drain_ur", 32'(underrun), 32'd1);
        push(7'h01);
        push(7'h02);
        push(7'h03);
        chk("q3_level", 32'(fifo_level), 32'd3);
        wait_t(100);
        reset_n = 1'b0;
        en      = 1'b0;
        @(negedge clk);
        chk("midrst_outs", {27'd0, bclk, lrclk, sdata, frame_start, underrun}, 32'd0);
        chk("midrst_level", 32'(fifo_level), 32'd0);
        chk("midrst_ready", 32'(s_ready), 32'd1);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
